// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer port arbiter.
// Tags follow each RAM read so the returning word goes to the requester that issued it.
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 8;

    localparam logic REQ_DISP = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } fb_tag_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester handshakes plus the RAM port of the framebuffer arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output disp_ack, disp_data, disp_valid, host_ack, host_rdata, host_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  disp_ack, disp_data, disp_valid, host_ack, host_rdata, host_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Shift register of {valid, id} tags that tracks RAM reads in flight.
// Asynchronous reset drops every outstanding tag.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  fb_tag_t tag_in,
    output fb_tag_t tag_out
);

    fb_tag_t [DEPTH-1:0] pipe_q;
    fb_tag_t [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Two-requester arbiter for the single-port framebuffer RAM: display reads win,
// host reads/writes fill the gaps; read data returns in issue order.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W  = FB_ADDR_W,
    parameter int DATA_W  = FB_DATA_W,
    parameter int RAM_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    fb_port_arbiter_if.slave bus
);

    logic              disp_ack_q, disp_ack_d;
    logic              host_ack_q, host_ack_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;

    logic    disp_elig, host_elig;
    logic    grant_disp, grant_host;
    fb_tag_t tag_in, tag_out;

    // A request whose ack is high this cycle is the same held request; skip it.
    always_comb begin
        disp_elig  = bus.disp_req && !disp_ack_q;
        host_elig  = bus.host_req && !host_ack_q;
        grant_disp = disp_elig;
        grant_host = host_elig && !disp_elig;

        disp_ack_d  = grant_disp;
        host_ack_d  = grant_host;
        ram_en_d    = grant_disp || grant_host;
        ram_we_d    = grant_host && bus.host_we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (grant_disp) begin
            ram_addr_d = bus.disp_addr;
        end else if (grant_host) begin
            ram_addr_d  = bus.host_addr;
            ram_wdata_d = bus.host_wdata;
        end

        tag_in.valid = grant_disp || (grant_host && !bus.host_we);
        tag_in.id    = grant_host ? REQ_HOST : REQ_DISP;

        disp_valid_d  = tag_out.valid && (tag_out.id == REQ_DISP);
        host_rvalid_d = tag_out.valid && (tag_out.id == REQ_HOST);
        disp_data_d   = disp_valid_d  ? bus.ram_rdata : disp_data_q;
        host_rdata_d  = host_rvalid_d ? bus.ram_rdata : host_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_ack_q    <= 1'b0;
            host_ack_q    <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            disp_ack_q    <= disp_ack_d;
            host_ack_q    <= host_ack_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            disp_data_q   <= disp_data_d;
            disp_valid_q  <= disp_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // The tag reaches the pipe exit in the cycle the RAM presents the word.
    fb_rd_tag_pipe #(
        .DEPTH(RAM_LAT + 1)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign bus.disp_ack    = disp_ack_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.disp_data   = disp_data_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;

endmodule
